// File: rtl/float_to_float_signed_pkg.sv
// Shared widths, bias/range helpers, lane class bits and flag indices for the
// IEEE-to-FloatSigned stream converter.
package float_to_float_signed_pkg;

  localparam int unsigned FLAG_UNF = 0;
  localparam int unsigned FLAG_OVF = 1;
  localparam int unsigned FLAG_NAN = 2;
  localparam int unsigned N_FLAGS  = 3;

  typedef struct packed {
    logic is_zero;
    logic is_denorm;
    logic is_inf;
    logic is_nan;
  } lane_class_t;

  function automatic int lane_in_w(input int exp_bits, input int frac_bits);
    return 1 + exp_bits + frac_bits;
  endfunction

  function automatic int lane_out_w(input int sexp_bits, input int sfrac_bits);
    return 3 + sexp_bits + sfrac_bits;
  endfunction

  function automatic int exp_bias(input int exp_bits);
    return (1 << (exp_bits - 1)) - 1;
  endfunction

  function automatic int signed_exp_max(input int sexp_bits);
    return (1 << (sexp_bits - 1)) - 1;
  endfunction

  function automatic int signed_exp_min(input int sexp_bits);
    return -(1 << (sexp_bits - 1));
  endfunction

  // Wide enough for renormalised denormals and a rounding carry without wrap.
  function automatic int ext_exp_w(input int exp_bits, input int sexp_bits);
    return ((exp_bits + 1 > sexp_bits) ? exp_bits + 1 : sexp_bits) + 1;
  endfunction

endpackage

// File: rtl/float_to_float_signed_lane.sv
// Per-lane stage-1 conversion: classify, renormalise denormals, and round the
// fraction to SIGNED_FRAC bits with a widened signed exponent.
module float_to_float_signed_lane
  import float_to_float_signed_pkg::*;
#(
  parameter int EXP         = 8,
  parameter int FRAC        = 23,
  parameter int SIGNED_EXP  = 3,
  parameter int SIGNED_FRAC = 8
) (
  input  logic [lane_in_w(EXP, FRAC)-1:0]             lane_in,
  input  logic                                        round_rne,
  output logic                                        sign,
  output lane_class_t                                 cls,
  output logic signed [ext_exp_w(EXP, SIGNED_EXP)-1:0] exp_w,
  output logic [SIGNED_FRAC-1:0]                      frac
);

  localparam int EW   = ext_exp_w(EXP, SIGNED_EXP);
  localparam int BIAS = exp_bias(EXP);
  localparam int LZW  = $clog2(FRAC + 1);

  logic [EXP-1:0]         exp_f;
  logic [FRAC-1:0]        frac_f;
  logic [FRAC-1:0]        mant;
  logic [LZW-1:0]         lz;
  logic signed [EW-1:0]   exp_pre;

  function automatic logic [LZW-1:0] count_lz(input logic [FRAC-1:0] v);
    logic [LZW-1:0] n;
    logic           found;
    n     = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < FRAC; i++) begin
      if (!found) begin
        if (v[FRAC-1-i]) found = 1'b1;
        else             n     = n + LZW'(1);
      end
    end
    return n;
  endfunction

  always_comb begin
    sign   = lane_in[FRAC+EXP];
    exp_f  = lane_in[FRAC +: EXP];
    frac_f = lane_in[FRAC-1:0];
    lz     = count_lz(frac_f);
    cls           = '0;
    cls.is_zero   = (exp_f == '0) && (frac_f == '0);
    cls.is_denorm = (exp_f == '0) && (frac_f != '0);
    cls.is_inf    = (exp_f == '1) && (frac_f == '0);
    cls.is_nan    = (exp_f == '1) && (frac_f != '0);
    if (cls.is_denorm) begin
      // Shift out the leading one too; exp = 1 - bias - (lz + 1).
      mant    = frac_f << (lz + LZW'(1));
      exp_pre = EW'(0) - EW'(BIAS) - EW'(lz);
    end else begin
      mant    = frac_f;
      exp_pre = EW'(exp_f) - EW'(BIAS);
    end
  end

  if (SIGNED_FRAC >= FRAC) begin : g_pad
    always_comb begin
      frac                         = '0;
      frac[SIGNED_FRAC-1 -: FRAC]  = mant;
      exp_w                        = exp_pre;
    end
  end else begin : g_round
    localparam int DROP = FRAC - SIGNED_FRAC;
    logic [SIGNED_FRAC-1:0] keep;
    logic [DROP+1:0]        tail;
    logic                   guard, rnd, sticky, inc, carry;

    always_comb begin
      keep   = mant[FRAC-1 -: SIGNED_FRAC];
      // Two zero pad bits keep guard/round/sticky well defined for DROP = 1.
      tail   = {mant[DROP-1:0], 2'b00};
      guard  = tail[DROP+1];
      rnd    = tail[DROP];
      sticky = |tail[DROP-1:0];
      inc    = round_rne && guard && (rnd || sticky || keep[0]);
      {carry, frac} = {1'b0, keep} + (SIGNED_FRAC + 1)'(inc);
      exp_w  = exp_pre + EW'(carry);
    end
  end

endmodule

// File: rtl/float_to_float_signed_stream.sv
// Two-stage valid/ready pipeline converting LANES IEEE floats per beat into
// FloatSigned lanes, with per-beat rounding/overflow policy and sticky flags.
module float_to_float_signed_stream
  import float_to_float_signed_pkg::*;
#(
  parameter int EXP         = 8,
  parameter int FRAC        = 23,
  parameter int SIGNED_EXP  = 3,
  parameter int SIGNED_FRAC = 8,
  parameter int LANES       = 4,
  parameter int DENORMALS   = 1
) (
  input  logic                                                clock,
  input  logic                                                reset,
  input  logic                                                in_valid,
  output logic                                                in_ready,
  input  logic [LANES*lane_in_w(EXP, FRAC)-1:0]               in_data,
  input  logic                                                cfg_saturate,
  input  logic                                                cfg_round_rne,
  output logic                                                out_valid,
  input  logic                                                out_ready,
  output logic [LANES*lane_out_w(SIGNED_EXP, SIGNED_FRAC)-1:0] out_data,
  output logic [2:0]                                          flags,
  input  logic                                                flags_clear
);

  localparam int IW = lane_in_w(EXP, FRAC);
  localparam int OW = lane_out_w(SIGNED_EXP, SIGNED_FRAC);
  localparam int EW = ext_exp_w(EXP, SIGNED_EXP);
  localparam logic signed [EW-1:0] EXP_MAX = EW'(signed_exp_max(SIGNED_EXP));
  localparam logic signed [EW-1:0] EXP_MIN = EW'(signed_exp_min(SIGNED_EXP));

  typedef struct packed {
    logic                   sign;
    lane_class_t            cls;
    logic [EW-1:0]          expo;
    logic [SIGNED_FRAC-1:0] frac;
  } s1_lane_t;

  s1_lane_t [LANES-1:0]   lane_res, s1_lane_d, s1_lane_q;
  logic                   s1_valid_d, s1_valid_q, s1_sat_d, s1_sat_q;
  logic                   s2_valid_d, s2_valid_q;
  logic [LANES*OW-1:0]    pack_data, s2_data_d, s2_data_q;
  logic [N_FLAGS-1:0]     pack_flags, s2_flags_d, s2_flags_q, flags_d, flags_q;
  logic                   s1_advance, accept;

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    logic                   sign_l;
    lane_class_t            cls_l;
    logic signed [EW-1:0]   exp_l;
    logic [SIGNED_FRAC-1:0] frac_l;

    float_to_float_signed_lane #(
      .EXP         (EXP),
      .FRAC        (FRAC),
      .SIGNED_EXP  (SIGNED_EXP),
      .SIGNED_FRAC (SIGNED_FRAC)
    ) u_lane (
      .lane_in   (in_data[l*IW +: IW]),
      .round_rne (cfg_round_rne),
      .sign      (sign_l),
      .cls       (cls_l),
      .exp_w     (exp_l),
      .frac      (frac_l)
    );

    assign lane_res[l] = {sign_l, cls_l, exp_l, frac_l};
  end

  always_comb begin
    s1_lane_t               cur;
    logic                   flush, fin, ovf, unf, o_inf, o_zero;
    logic [SIGNED_EXP-1:0]  o_exp;
    logic [SIGNED_FRAC-1:0] o_frac;
    pack_data  = '0;
    pack_flags = '0;
    for (int unsigned l = 0; l < LANES; l++) begin
      cur    = s1_lane_q[l];
      flush  = cur.cls.is_denorm && (DENORMALS == 0);
      fin    = !(cur.cls.is_zero || cur.cls.is_inf || cur.cls.is_nan || flush);
      ovf    = fin && ($signed(cur.expo) > EXP_MAX);
      unf    = fin && ($signed(cur.expo) < EXP_MIN);
      o_inf  = 1'b0;
      o_zero = 1'b0;
      o_exp  = '0;
      o_frac = '0;
      if (cur.cls.is_inf || cur.cls.is_nan) begin
        o_inf = 1'b1;
      end else if (ovf) begin
        if (s1_sat_q) begin
          o_exp  = EXP_MAX[SIGNED_EXP-1:0];
          o_frac = '1;
        end else begin
          o_inf = 1'b1;
        end
      end else if (cur.cls.is_zero || unf || flush) begin
        o_zero = 1'b1;
      end else begin
        o_exp  = cur.expo[SIGNED_EXP-1:0];
        o_frac = cur.frac;
      end
      pack_data[l*OW +: OW] = {cur.sign, o_inf, o_zero, o_exp, o_frac};
      pack_flags[FLAG_NAN] = pack_flags[FLAG_NAN] | cur.cls.is_nan;
      pack_flags[FLAG_OVF] = pack_flags[FLAG_OVF] | ovf;
      pack_flags[FLAG_UNF] = pack_flags[FLAG_UNF] | unf | flush;
    end
  end

  always_comb begin
    s1_advance = !s2_valid_q || out_ready;
    in_ready   = !s1_valid_q || s1_advance;
    accept     = in_valid && in_ready;

    s1_valid_d = s1_valid_q;
    s1_lane_d  = s1_lane_q;
    s1_sat_d   = s1_sat_q;
    if (in_ready) s1_valid_d = in_valid;
    if (accept) begin
      s1_lane_d = lane_res;
      s1_sat_d  = cfg_saturate;
    end

    s2_valid_d = s2_valid_q;
    s2_data_d  = s2_data_q;
    s2_flags_d = s2_flags_q;
    if (s1_advance) s2_valid_d = s1_valid_q;
    if (s1_advance && s1_valid_q) begin
      s2_data_d  = pack_data;
      s2_flags_d = pack_flags;
    end

    // Clear first so an event leaving stage 2 in the same cycle still lands.
    flags_d = flags_clear ? '0 : flags_q;
    if (s2_valid_q && out_ready) flags_d = flags_d | s2_flags_q;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      s1_valid_q <= 1'b0;
      s1_lane_q  <= '0;
      s1_sat_q   <= 1'b0;
      s2_valid_q <= 1'b0;
      s2_data_q  <= '0;
      s2_flags_q <= '0;
      flags_q    <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_lane_q  <= s1_lane_d;
      s1_sat_q   <= s1_sat_d;
      s2_valid_q <= s2_valid_d;
      s2_data_q  <= s2_data_d;
      s2_flags_q <= s2_flags_d;
      flags_q    <= flags_d;
    end
  end

  assign out_valid = s2_valid_q;
  assign out_data  = s2_data_q;
  assign flags     = flags_q;

endmodule

// File: tb/tb_float_to_float_signed_stream.sv
// Directed bench: vector table on the default configuration plus hand-written
// stream, reset, flag and half-precision denormal sequences.
module tb_float_to_float_signed_stream;

  logic         clock = 1'b0;
  logic         reset;
  logic         in_valid, in_ready;
  logic [127:0] in_data;
  logic         cfg_saturate, cfg_round_rne;
  logic         out_valid, out_ready;
  logic [55:0]  out_data;
  logic [2:0]   flags;
  logic         flags_clear;

  logic         h_valid;
  logic [15:0]  h_data;
  logic         h1_in_ready, h1_out_valid, h0_in_ready, h0_out_valid;
  logic [16:0]  h1_out_data, h0_out_data;
  logic [2:0]   h1_flags, h0_flags;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clock = ~clock;

  float_to_float_signed_stream dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .cfg_saturate(cfg_saturate), .cfg_round_rne(cfg_round_rne),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .flags(flags), .flags_clear(flags_clear)
  );

  float_to_float_signed_stream #(
    .EXP(5), .FRAC(10), .SIGNED_EXP(6), .SIGNED_FRAC(8), .LANES(1), .DENORMALS(1)
  ) dut_h1 (
    .clock(clock), .reset(reset), .in_valid(h_valid), .in_ready(h1_in_ready),
    .in_data(h_data), .cfg_saturate(cfg_saturate), .cfg_round_rne(cfg_round_rne),
    .out_valid(h1_out_valid), .out_ready(out_ready), .out_data(h1_out_data),
    .flags(h1_flags), .flags_clear(flags_clear)
  );

  float_to_float_signed_stream #(
    .EXP(5), .FRAC(10), .SIGNED_EXP(6), .SIGNED_FRAC(8), .LANES(1), .DENORMALS(0)
  ) dut_h0 (
    .clock(clock), .reset(reset), .in_valid(h_valid), .in_ready(h0_in_ready),
    .in_data(h_data), .cfg_saturate(cfg_saturate), .cfg_round_rne(cfg_round_rne),
    .out_valid(h0_out_valid), .out_ready(out_ready), .out_data(h0_out_data),
    .flags(h0_flags), .flags_clear(flags_clear)
  );

  typedef struct {
    logic [31:0] din;
    logic        sat;
    logic        rne;
    logic [13:0] lane_out;
    logic [2:0]  flg;
  } vec_t;

  vec_t         vt [23];
  logic [127:0] s_in  [8];
  logic         s_sat [8];
  logic [55:0]  s_exp [8];

  function automatic logic [13:0] mk(input logic s, input logic inf, input logic z,
                                     input logic [2:0] e, input logic [7:0] f);
    return {s, inf, z, e, f};
  endfunction

  function automatic logic [16:0] mk6(input logic s, input logic inf, input logic z,
                                      input logic [5:0] e, input logic [7:0] f);
    return {s, inf, z, e, f};
  endfunction

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, want);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic run_stream(input int n, input int stall_lo, input int stall_hi, input string tag);
    int n_in = 0, n_out = 0, occ = 0;
    logic acc, emit;
    for (int c = 0; c < 60 && n_out < n; c++) begin
      out_ready = !(c >= stall_lo && c <= stall_hi);
      in_valid  = (n_in < n);
      if (n_in < n) begin
        in_data      = s_in[n_in];
        cfg_saturate = s_sat[n_in];
      end
      #1;
      check($sformatf("%s in_ready c%0d", tag, c), in_ready, !(occ == 2 && !out_ready));
      if (out_valid)
        check($sformatf("%s beat%0d c%0d", tag, n_out, c), out_data, s_exp[n_out]);
      acc  = in_valid && in_ready;
      emit = out_valid && out_ready;
      tick();
      n_in  += int'(acc);
      n_out += int'(emit);
      occ   += int'(acc) - int'(emit);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    check({tag, " beats in"}, n_in, n);
    check({tag, " beats out"}, n_out, n);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [55:0] want;
    int          lat, lane;
    logic        seen;

    vt[0]  = '{32'h3F800000, 1'b1, 1'b1, mk(0,0,0,3'd0,8'h00), 3'b000};
    vt[1]  = '{32'hBF800000, 1'b1, 1'b1, mk(1,0,0,3'd0,8'h00), 3'b000};
    vt[2]  = '{32'h00000000, 1'b1, 1'b1, mk(0,0,1,3'd0,8'h00), 3'b000};
    vt[3]  = '{32'h80000000, 1'b1, 1'b1, mk(1,0,1,3'd0,8'h00), 3'b000};
    vt[4]  = '{32'h7FC00000, 1'b1, 1'b1, mk(0,1,0,3'd0,8'h00), 3'b100};
    vt[5]  = '{32'h7F800000, 1'b1, 1'b1, mk(0,1,0,3'd0,8'h00), 3'b000};
    vt[6]  = '{32'hFF800000, 1'b1, 1'b1, mk(1,1,0,3'd0,8'h00), 3'b000};
    vt[7]  = '{32'h41800000, 1'b1, 1'b1, mk(0,0,0,3'd3,8'hFF), 3'b010};
    vt[8]  = '{32'h41800000, 1'b0, 1'b1, mk(0,1,0,3'd0,8'h00), 3'b010};
    vt[9]  = '{32'hC1800000, 1'b0, 1'b1, mk(1,1,0,3'd0,8'h00), 3'b010};
    vt[10] = '{32'h41000000, 1'b1, 1'b1, mk(0,0,0,3'd3,8'h00), 3'b000};
    vt[11] = '{32'h3D800000, 1'b1, 1'b1, mk(0,0,0,3'd4,8'h00), 3'b000};
    vt[12] = '{32'h3D000000, 1'b1, 1'b1, mk(0,0,1,3'd0,8'h00), 3'b001};
    vt[13] = '{32'h00000001, 1'b1, 1'b1, mk(0,0,1,3'd0,8'h00), 3'b001};
    vt[14] = '{32'h3F804000, 1'b1, 1'b1, mk(0,0,0,3'd0,8'h00), 3'b000};
    vt[15] = '{32'h3F80C000, 1'b1, 1'b1, mk(0,0,0,3'd0,8'h02), 3'b000};
    vt[16] = '{32'h3F80C000, 1'b1, 1'b0, mk(0,0,0,3'd0,8'h01), 3'b000};
    vt[17] = '{32'h3FFFFFFF, 1'b1, 1'b1, mk(0,0,0,3'd1,8'h00), 3'b000};
    vt[18] = '{32'h3FFFFFFF, 1'b1, 1'b0, mk(0,0,0,3'd0,8'hFF), 3'b000};
    vt[19] = '{32'hC0400000, 1'b1, 1'b1, mk(1,0,0,3'd1,8'h80), 3'b000};
    vt[20] = '{32'h417FFFFF, 1'b1, 1'b1, mk(0,0,0,3'd3,8'hFF), 3'b010};
    vt[21] = '{32'h3F7FFFFF, 1'b1, 1'b1, mk(0,0,0,3'd0,8'h00), 3'b000};
    vt[22] = '{32'h3F804001, 1'b1, 1'b1, mk(0,0,0,3'd0,8'h01), 3'b000};

    reset = 1'b1; in_valid = 1'b0; in_data = '0; cfg_saturate = 1'b1;
    cfg_round_rne = 1'b1; out_ready = 1'b1; flags_clear = 1'b0;
    h_valid = 1'b0; h_data = '0;
    tick(); tick();
    check("reset out_valid", out_valid, 0);
    check("reset in_ready", in_ready, 1);
    check("reset flags", flags, 0);
    check("reset out_data", out_data, 0);
    reset = 1'b0;

    for (int i = 0; i < 23; i++) begin
      lane = i % 4;
      flags_clear = 1'b1;
      tick();
      flags_clear = 1'b0;
      for (int j = 0; j < 4; j++)
        in_data[j*32 +: 32] = (j == lane) ? vt[i].din : 32'h3F800000;
      want = '0;
      want[lane*14 +: 14] = vt[i].lane_out;
      cfg_saturate  = vt[i].sat;
      cfg_round_rne = vt[i].rne;
      in_valid = 1'b1;
      #1;
      check($sformatf("vec%0d in_ready", i), in_ready, 1);
      tick();
      in_valid = 1'b0;
      lat = 1;
      while (!out_valid && lat < 8) begin
        tick();
        lat++;
      end
      check($sformatf("vec%0d latency", i), lat, 2);
      check($sformatf("vec%0d data", i), out_data, want);
      tick();
      check($sformatf("vec%0d flags", i), flags, vt[i].flg);
    end

    // Half-precision denormals: renormalised vs flushed.
    flags_clear = 1'b1;
    tick();
    flags_clear = 1'b0;
    cfg_saturate = 1'b1; cfg_round_rne = 1'b1;
    h_data = 16'h0001; h_valid = 1'b1;
    #1;
    check("half in_ready d1", h1_in_ready, 1);
    check("half in_ready d0", h0_in_ready, 1);
    tick();
    h_valid = 1'b0;
    tick();
    check("half 0001 d1 valid", h1_out_valid, 1);
    check("half 0001 d1 data", h1_out_data, mk6(0,0,0,6'h28,8'h00));
    check("half 0001 d0 valid", h0_out_valid, 1);
    check("half 0001 d0 data", h0_out_data, mk6(0,0,1,6'h00,8'h00));
    tick();
    check("half 0001 d1 flags", h1_flags, 3'b000);
    check("half 0001 d0 flags", h0_flags, 3'b001);
    h_data = 16'h8200; h_valid = 1'b1;
    tick();
    h_valid = 1'b0;
    tick();
    check("half 8200 d1 data", h1_out_data, mk6(1,0,0,6'h31,8'h00));
    check("half 8200 d0 data", h0_out_data, mk6(1,0,1,6'h00,8'h00));
    tick();
    check("half 8200 d1 flags", h1_flags, 3'b000);

    // Six distinct beats with out_ready low in cycles 3..7.
    cfg_round_rne = 1'b1;
    for (int k = 0; k < 6; k++) begin
      s_sat[k] = 1'b1;
      for (int j = 0; j < 4; j++) begin
        s_in[k][j*32 +: 32]  = 32'h3F800000 | (32'(k*4 + j) << 15);
        s_exp[k][j*14 +: 14] = mk(0, 0, 0, 3'd0, 8'(k*4 + j));
      end
    end
    run_stream(6, 3, 7, "bp");

    // cfg_saturate toggled on back-to-back overflow beats.
    for (int k = 0; k < 3; k++) begin
      s_in[k]  = {4{32'h41800000}};
      s_sat[k] = (k != 1);
      s_exp[k] = (k != 1) ? {4{mk(0,0,0,3'd3,8'hFF)}} : {4{mk(0,1,0,3'd0,8'h00)}};
    end
    run_stream(3, 100, 0, "sat");

    // NaN sets nan_seen; clear coincident with an overflow beat leaving stage 2.
    flags_clear = 1'b1;
    tick();
    flags_clear = 1'b0;
    in_data = {{3{32'h3F800000}}, 32'h7FC00000};
    cfg_saturate = 1'b1;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick(); tick();
    check("nan flag set", flags, 3'b100);
    in_data = {4{32'h41800000}};
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    check("clr beat pending", out_valid, 0);
    tick();
    check("clr beat valid", out_valid, 1);
    flags_clear = 1'b1;
    tick();
    flags_clear = 1'b0;
    check("clear vs overflow", flags, 3'b010);

    // Reset with two beats in flight, the second accepted on the reset edge.
    in_data = {4{32'h3F800000}};
    in_valid = 1'b1;
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    in_valid = 1'b0;
    check("rst flight out_valid", out_valid, 0);
    check("rst flight in_ready", in_ready, 1);
    check("rst flight out_data", out_data, 0);
    check("rst flight flags", flags, 0);
    seen = 1'b0;
    for (int c = 0; c < 5; c++) begin
      if (out_valid) seen = 1'b1;
      tick();
    end
    check("rst flight nothing emerges", seen, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule
